// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one busywait-style memory between the instruction
// fetch port and the data port. Each granted request is latched for the
// whole transfer, ties alternate between the ports, and read data is
// returned only to the port that won.
module mem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_write_q, op_write_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic i_req, d_req;
    logic grant_i, grant_d;

    assign i_req = i_read;
    // A simultaneous read and write on the data port is treated as a write.
    assign d_req = d_read | d_write;

    // Arbitration: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        grant_i = i_req && (!d_req || (last_grant_q == GRANT_D));
        grant_d = d_req && (!i_req || (last_grant_q == GRANT_I));
    end

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grants only leave IDLE, completion is the memory
    // dropping busywait, and DONE always lasts exactly one cycle.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path
        // covered, so no latch is inferred when a branch leaves it untouched.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = SERVE_I;
                end else if (grant_d) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: if (!mem_busywait) state_d = DONE_I;
            SERVE_D: if (!mem_busywait) state_d = DONE_D;
            DONE_I:  state_d = IDLE;
            DONE_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the winner's request on grant and capture
    // read data into the winner's register on completion.
    always_comb begin
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_write_d   = op_write_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    addr_d       = i_address;
                    op_write_d   = 1'b0;
                    last_grant_d = GRANT_I;
                end else if (grant_d) begin
                    addr_d       = d_address;
                    wdata_d      = d_writedata;
                    op_write_d   = d_write;
                    last_grant_d = GRANT_D;
                end
            end
            SERVE_I: begin
                if (!mem_busywait) i_rdata_d = mem_readdata;
            end
            SERVE_D: begin
                if (!mem_busywait && !op_write_q) d_rdata_d = mem_readdata;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset abandons any transfer in flight and hands
    // the next tie back to the instruction port.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_write_q   <= op_write_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Outputs: strobes decode registered state only; a port stalls whenever
    // it requests, except in its own DONE cycle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            SERVE_I: mem_read = 1'b1;
            SERVE_D: begin
                mem_read  = !op_write_q;
                mem_write = op_write_q;
            end
            default: ;
        endcase
        i_busywait = i_req && (state_q != DONE_I);
        d_busywait = d_req && (state_q != DONE_D);
    end

    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign i_readdata    = i_rdata_q;
    assign d_readdata    = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one backing memory (busywait handshake) between the instruction-fetch path and the data path of the 8-bit single-cycle CPU. It sits between the instruction cache/fetch unit and the data cache on one side and the single main-memory model on the other. It serialises their block transfers and alternates grants fairly under contention. It latches each granted request and returns read data to the winning port only.

## Interface
Parameters:
- ADDR_W, 6, memory block-address width
- DATA_W, 32, memory block-data width

Ports:
- CLK  in  1  system clock, all state updates on posedge
- RESET  in  1  synchronous, active-high; sampled on posedge CLK
- i_read  in  1  instruction-port read request, held until i_busywait low
- i_address  in  ADDR_W  instruction-port block address
- i_readdata  out  DATA_W  instruction-port read data, registered
- i_busywait  out  1  instruction-port stall
- d_read  in  1  data-port read request, held until d_busywait low
- d_write  in  1  data-port write request, held until d_busywait low
- d_address  in  ADDR_W  data-port block address
- d_writedata  in  DATA_W  data-port write data
- d_readdata  out  DATA_W  data-port read data, registered
- d_busywait  out  1  data-port stall
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  latched address of the granted request
- mem_writedata  out  DATA_W  latched write data
- mem_readdata  in  DATA_W  memory read data, valid when mem_busywait low
- mem_busywait  in  1  memory busy; memory raises it in the same cycle the strobe rises and drops it when the access completes

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D. Reset state: IDLE.
- Register last_grant (I or D). Reset value: D, so I wins the first tie.
- IDLE behaviour:
  - Only I requests (i_read): go to SERVE_I.
  - Only D requests (d_read|d_write): go to SERVE_D.
  - Both request: grant the port opposite to last_grant.
  - On grant: latch address, write data (D only), op type; update last_grant.
- SERVE_x: drive mem_read or mem_write from the latched op. When posedge samples mem_busywait==0: capture mem_readdata into x_readdata (reads only) and go to DONE_x.
- DONE_x: strobes low; x_busywait low for exactly this one cycle; next state IDLE.
- x_busywait (combinational) = x request asserted AND state != DONE_x.
  - A losing or waiting port stays stalled.
  - A port with no request reads busywait low.
- d_read and d_write both high: treat as write. No new op is accepted while in SERVE/DONE; request inputs are ignored except for busywait.
- Latched values are used for the whole transaction; requester input changes mid-transaction have no effect.
- Reset values: mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, i_readdata=0, d_readdata=0.
- Reset mid-transaction: next posedge forces IDLE, strobes drop, the transaction is abandoned, no readdata update. last_grant returns to D.

## Timing
- Request raised in cycle 0 (IDLE): grant at edge 1; strobe high during cycle 1.
- Memory busy for L cycles: edge 1+L samples busywait low → DONE at cycle 1+L; readdata valid from that edge.
- Uncontended latency, request to busywait low: L+1 cycles. Requester drops or renews its request at the edge leaving DONE.
- Contended loser waits the winner's full L+2 cycles plus its own L+1.
- Back-to-back requests from the same port: at least one IDLE cycle between transactions.
- Strobes are registered-state outputs: no glitches and no combinational path from requester inputs to mem_*.

## Test plan
- Single I read, address 6'h05, memory returns 32'hDEADBEEF after L=5:
  - mem_read high cycles 1–5.
  - i_busywait low only in cycle 6.
  - i_readdata=32'hDEADBEEF.
  - d_busywait low throughout.
- D write, address 6'h3F, data 32'hA5A5A5A5:
  - mem_write=1 with the latched address and data.
  - d_readdata unchanged (0).
  - d_busywait low for exactly one cycle.
- Simultaneous i_read and d_read first after reset:
  - I served first, then D.
  - Second simultaneous pair: D then I (alternation verified over 4 rounds).
- Requester changes d_address from 6'h01 to 6'h02 during SERVE_D: mem_address stays 6'h01 until DONE.
- RESET asserted in the 3rd cycle of SERVE_I:
  - Next edge: IDLE, mem_read=0, i_readdata unchanged.
  - A following D-only request is granted normally.
- d_read and d_write both high, data 32'h12345678: mem_write=1, mem_read=0.
